// File: rtl/ripple_sub_pkg.sv
// Shared types and constants for the bit-serial ripple subtractor.
package ripple_sub_pkg;

    localparam int WIDTH_DEF = 4;
    // Bit counter wide enough for the largest legal WIDTH (16 -> index 0..15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/ripple_subtractor_serial_full_subtractor.sv
// One-bit full subtractor built from gate primitives: D = X-Y-Bi, Bo = borrow out.
module full_subtractor (
    input  logic X,
    input  logic Y,
    input  logic Bi,
    output wire  D,
    output wire  Bo
);

    wire xy;
    wire nx;
    wire nxy;
    wire t0;
    wire t1;

    xor g_xy (xy, X, Y);
    xor g_d  (D, xy, Bi);
    not g_nx (nx, X);
    and g_t0 (t0, nx, Y);
    not g_nxy(nxy, xy);
    and g_t1 (t1, nxy, Bi);
    or  g_bo (Bo, t0, t1);

endmodule

// File: rtl/ripple_subtractor_serial.sv
// Bit-serial X-Y-Bin subtractor, one bit per clock, LSB first through a single full_subtractor.
// Define RIPPLE_SUB_OVF_EN to add the registered signed-overflow output OVF.
//
// state | meaning
// IDLE  | waiting for start; D/Bout hold last result
// RUN   | WIDTH cycles, one difference bit per cycle
// DONE  | one cycle, done=1 with D/Bout freshly valid; start here re-launches
module ripple_subtractor_serial
    import ripple_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             busy,
    output logic             done
`ifdef RIPPLE_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] res;
    logic             b;
    logic [CNT_W-1:0] cnt;
    wire              d_bit;
    wire              b_nxt;

    full_subtractor u_fs (
        .D (d_bit),
        .Bo(b_nxt),
        .X (x_sh[0]),
        .Y (y_sh[0]),
        .Bi(b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x_sh  <= '0;
            y_sh  <= '0;
            res   <= '0;
            b     <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            Bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef RIPPLE_SUB_OVF_EN
            OVF   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_sh  <= X;
                        y_sh  <= Y;
                        b     <= Bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    x_sh <= x_sh >> 1;
                    y_sh <= y_sh >> 1;
                    res  <= {d_bit, res[WIDTH-1:1]};
                    b    <= b_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // On the last bit the shift registers hold the operand MSBs.
                        D     <= {d_bit, res[WIDTH-1:1]};
                        Bout  <= b_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
`ifdef RIPPLE_SUB_OVF_EN
                        OVF   <= (x_sh[0] != y_sh[0]) && (d_bit != x_sh[0]);
`endif
                    end
                end
                DONE: begin
                    if (start) begin
                        x_sh  <= X;
                        y_sh  <= Y;
                        b     <= Bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_subtractor_serial.sv
// Directed-vector bench for ripple_subtractor_serial (WIDTH=4), hand-computed expectations.
module tb_ripple_subtractor_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Bin;
    logic [W-1:0] D;
    logic         Bout;
    logic         busy;
    logic         done;
`ifdef RIPPLE_SUB_OVF_EN
    logic         OVF;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    ripple_subtractor_serial #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .X    (X),
        .Y    (Y),
        .Bin  (Bin),
        .D    (D),
        .Bout (Bout),
        .busy (busy),
        .done (done)
`ifdef RIPPLE_SUB_OVF_EN
        ,
        .OVF  (OVF)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 30) begin
            tick();
            cyc++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input string tag, input int x, input int y, input int bi,
                          input int exp_d, input int exp_b);
        int cyc;
        X = W'(x); Y = W'(y); Bin = bi[0]; start = 1'b1;
        tick();
        check({tag, "_busy"}, int'(busy), 1);
        start = 1'b0;
        wait_done(cyc);
        check({tag, "_lat"}, cyc, W);
        check({tag, "_D"}, int'(D), exp_d);
        check({tag, "_Bout"}, int'(Bout), exp_b);
        check({tag, "_busy_done"}, int'(busy), 0);
        tick();
        check({tag, "_pulse"}, int'(done), 0);
    endtask

    initial begin
        int cyc;
        int ndone;

        rst = 1'b1; start = 1'b0; X = '0; Y = '0; Bin = 1'b0;
        repeat (3) tick();
        check("rst_D", int'(D), 0);
        check("rst_Bout", int'(Bout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        tick();

        run_op("9m5", 9, 5, 0, 4, 0);
        run_op("5m9", 5, 9, 0, 12, 1);
        run_op("0m0b", 0, 0, 1, 15, 1);
        run_op("15m15b", 15, 15, 1, 15, 1);
        run_op("8m3b", 8, 3, 1, 4, 0);
        run_op("7m7", 7, 7, 0, 0, 0);

        // Start pulses during RUN cycles 2 and 3 must be ignored.
        X = 4'd10; Y = 4'd3; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        X = 4'd1; Y = 4'd2; Bin = 1'b1; start = 1'b1;
        check("hold_D_mid", int'(D), 0);
        tick();
        tick();
        start = 1'b0;
        wait_done(cyc);
        check("ign_lat", cyc + 3, W);
        check("ign_D", int'(D), 7);
        check("ign_Bout", int'(Bout), 0);
        ndone = 0;
        repeat (8) begin tick(); if (done) ndone++; end
        check("ign_no_extra_done", ndone, 0);
        check("ign_idle", int'(busy), 0);

        // Reset during RUN cycle 2 abandons the operation.
        X = 4'd9; Y = 4'd5; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_D", int'(D), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_D", int'(D), 0);
        check("mid_rst_Bout", int'(Bout), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        ndone = 0;
        repeat (8) begin tick(); if (done) ndone++; end
        check("mid_rst_no_done", ndone, 0);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; X = 4'd6; Y = 4'd1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", int'(busy), 0);
        tick();
        check("rst_prio_still_idle", int'(busy), 0);

        // Continuous start: back-to-back results every WIDTH+1 cycles.
        X = 4'd15; Y = 4'd1; Bin = 1'b0; start = 1'b1;
        tick();
        X = 4'd3; Y = 4'd3;
        wait_done(cyc);
        check("b2b1_lat", cyc, W);
        check("b2b1_D", int'(D), 14);
        check("b2b1_Bout", int'(Bout), 0);
        tick();
        check("b2b_relaunch_busy", int'(busy), 1);
        wait_done(cyc);
        check("b2b_period", cyc + 1, W + 1);
        check("b2b2_D", int'(D), 0);
        check("b2b2_Bout", int'(Bout), 0);
        start = 1'b0;
        tick();
        tick();

`ifdef RIPPLE_SUB_OVF_EN
        run_op("ovf7m8", 7, 8, 0, 15, 1);
        check("ovf7m8_OVF", int'(OVF), 1);
        run_op("ovf3m1", 3, 1, 0, 2, 0);
        check("ovf3m1_OVF", int'(OVF), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
